// File: rtl/div_pkg.sv
// Shared types and defaults for the divider result queue.
package div_pkg;

    localparam int unsigned DIV_W_DEFAULT = 10;

    typedef enum logic [1:0] {
        DIV_OK  = 2'd0,
        DIV_DVZ = 2'd1,
        DIV_OVF = 2'd2
    } div_status_e;

endpackage

// File: rtl/div_rq_fifo.sv
// Circular FIFO holding divider results; extra pointer MSB separates full from empty.
module div_rq_fifo
    import div_pkg::*;
#(
    parameter int unsigned W     = DIV_W_DEFAULT,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [W-1:0]                 push_q_i,
    input  div_status_e                  push_st_i,
    input  logic                         pop_i,
    output logic                         out_valid_o,
    output logic [W-1:0]                 out_q_o,
    output div_status_e                  out_st_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         drop_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [W-1:0]  q_mem_q  [DEPTH];
    div_status_e   st_mem_q [DEPTH];

    logic empty, full, pop_ok, push_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign pop_ok  = pop_i && !empty;
    // A full queue only takes a new entry when the head leaves in the same cycle.
    assign push_ok = push_i && (!full || pop_ok);
    assign drop_o  = push_i && full && !pop_ok;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately unreset; the head is masked while empty.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            q_mem_q[wr_ptr_q[AW-1:0]]  <= push_q_i;
            st_mem_q[wr_ptr_q[AW-1:0]] <= push_st_i;
        end
    end

    assign out_valid_o = !empty;
    assign out_q_o     = empty ? '0 : q_mem_q[rd_ptr_q[AW-1:0]];
    assign out_st_o    = empty ? DIV_OK : st_mem_q[rd_ptr_q[AW-1:0]];
    assign count_o     = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/div_result_queue.sv
// Result queue behind the divider: tracks in-flight operations and buffers outcomes.
module div_result_queue
    import div_pkg::*;
#(
    parameter int unsigned W     = DIV_W_DEFAULT,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         issue,
    input  logic [W-1:0] div_q,
    input  logic         div_valid,
    input  logic         div_dvz,
    input  logic         div_ovf,
    output logic         can_issue,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_q,
    output logic [1:0]   out_status,
    output logic         err_drop,
    output logic         err_unexp
);

    localparam int unsigned PW = $clog2(DEPTH) + 1;
    localparam int unsigned SW = PW + 1;

    logic [PW-1:0] pending_q, pending_d;
    logic          err_drop_q, err_drop_d;
    logic          err_unexp_q, err_unexp_d;
    logic [PW-1:0] count;
    logic          fifo_drop;
    logic          capture, issue_ok;
    div_status_e   cap_st, head_st;
    logic [W-1:0]  cap_q;

    assign capture = div_valid | div_dvz | div_ovf;

    // Exactly one entry per capture; error results carry no quotient.
    always_comb begin
        cap_st = DIV_OK;
        if (div_dvz)      cap_st = DIV_DVZ;
        else if (div_ovf) cap_st = DIV_OVF;
        cap_q = (cap_st == DIV_OK) ? div_q : '0;
    end

    div_rq_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (capture),
        .push_q_i    (cap_q),
        .push_st_i   (cap_st),
        .pop_i       (out_ready),
        .out_valid_o (out_valid),
        .out_q_o     (out_q),
        .out_st_o    (head_st),
        .count_o     (count),
        .drop_o      (fifo_drop)
    );

    assign out_status = head_st;
    assign can_issue  = (SW'(count) + SW'(pending_q)) < SW'(DEPTH);
    assign issue_ok   = issue && can_issue;

    // Pending tracks issued-but-uncaptured work; an unmatched capture saturates at 0.
    always_comb begin
        pending_d   = pending_q;
        err_drop_d  = err_drop_q | fifo_drop;
        err_unexp_d = err_unexp_q;
        if (issue_ok && !capture) begin
            pending_d = pending_q + PW'(1);
        end else if (!issue_ok && capture) begin
            if (pending_q == '0) err_unexp_d = 1'b1;
            else                 pending_d   = pending_q - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q   <= '0;
            err_drop_q  <= 1'b0;
            err_unexp_q <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            err_drop_q  <= err_drop_d;
            err_unexp_q <= err_unexp_d;
        end
    end

    assign err_drop  = err_drop_q;
    assign err_unexp = err_unexp_q;

endmodule

// File: doc/div_result_queue.md
DIV_RESULT_QUEUE -- requirements
Module: div_result_queue

Interface
REQ-001 SHALL have parameter W, default 10, quotient width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, queue entries; legal values are powers of two, 2 to 16.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port issue  input  1  one-cycle pulse when upstream asserts Start to the divider.
REQ-006 SHALL have port div_q  input  W  divider quotient, sampled only when a capture occurs.
REQ-007 SHALL have port div_valid  input  1  divider Done pulse (one cycle).
REQ-008 SHALL have port div_dvz  input  1  divider divide-by-zero pulse.
REQ-009 SHALL have port div_ovf  input  1  divider overflow pulse.
REQ-010 SHALL have port can_issue  output  1  high when (count + pending) < DEPTH; upstream may pulse issue only while high.
REQ-011 SHALL have port out_valid  output  1  head entry available.
REQ-012 SHALL have port out_ready  input  1  consumer accepts head when out_valid is high.
REQ-013 SHALL have port out_q  output  W  head quotient; forced to 0 for DVZ and OVF entries.
REQ-014 SHALL have port out_status  output  2  head status: 0 OK, 1 DVZ, 2 OVF.
REQ-015 SHALL have port err_drop  output  1  sticky flag: a capture was lost because the queue was full.
REQ-016 SHALL have port err_unexp  output  1  sticky flag: a capture arrived while pending was 0.

Function
REQ-017 SHALL treat a capture as (div_valid | div_dvz | div_ovf) in a cycle.
REQ-018 SHALL resolve simultaneous pulses by priority DVZ > OVF > OK and store exactly one entry.
REQ-019 SHALL operate as a circular FIFO with read and write pointers of log2(DEPTH)+1 bits; the extra MSB distinguishes full from empty on wrap-around.
REQ-020 SHALL make a pushed entry visible on out_valid in the cycle after the capture (latency 1); there is no same-cycle bypass.
REQ-021 SHALL pop on out_valid & out_ready; head outputs SHALL be stable while out_valid is high and out_ready is low.
REQ-022 SHALL accept a push when full only if a pop occurs in the same cycle; the count is then unchanged.
REQ-023 SHALL drop a capture when full with no pop, leaving the pointers unchanged and setting err_drop.
REQ-024 SHALL ignore out_ready when empty, with no pointer movement.
REQ-025 SHALL keep pending, a 0..DEPTH counter of issued-but-uncaptured operations: +1 on issue, -1 on capture, unchanged when both occur.
REQ-026 SHALL saturate pending at 0 on a capture with pending 0, setting err_unexp; the entry is still stored if space exists.
REQ-027 SHALL ignore issue while can_issue is low; pending SHALL not increment.
REQ-028 SHALL compute can_issue combinationally from registered count and pending.

Reset
REQ-029 SHALL, while rst is high, clear the pointers, count, pending, err_drop and err_unexp; out_valid=0, can_issue=1, out_q=0, out_status=0.
REQ-030 SHALL discard all stored entries on reset asserted mid-operation; captures and issues in the reset cycle SHALL be ignored.
REQ-031 SHALL leave storage array contents unreset; outputs SHALL be masked to 0 when empty.

Structure
REQ-032 SHALL place the status typedef (DIV_OK=0, DIV_DVZ=1, DIV_OVF=2) and the default W constant in shared package div_pkg.
REQ-033 SHALL implement storage and pointers in one sub-module div_rq_fifo; pending/flag logic SHALL reside in the top.

Verification
REQ-034 SHALL verify basic flow: issue, then div_valid with div_q=0x155 -> next cycle out_valid=1, out_q=0x155, out_status=0; pending back to 0.
REQ-035 SHALL verify back-pressure: 4 issues, 4 div_valid, out_ready=0 -> can_issue=0 after the 4th issue; a 5th issue is ignored and pending stays 4.
REQ-036 SHALL verify full-and-pop: queue full, out_ready=1 with a capture of q=0x3FF in the same cycle -> count stays 4 and 0x3FF emerges last in order.
REQ-037 SHALL verify drop: queue full, out_ready=0, forced div_valid -> err_drop=1, queue contents unchanged.
REQ-038 SHALL verify priority: div_dvz and div_valid together with pending 1 -> one entry, out_status=1, out_q=0.
REQ-039 SHALL verify reset mid-run: 3 entries held, rst pulsed -> out_valid=0, can_issue=1, both err flags 0.
